tracer_udma_cfg_master: RTL and testbench

Initiator-side sequencer for the uDMA peripheral configuration bus of the tracer adapter. On a start request it programs one RX channel (start address, size, config/enable) over the 5-bit-address cfg bus, then periodically polls the channel until the transfer drains, exposing progress and completion to a local controller. It sits between the trace-debugger control logic and the tracer adapter's register interface, so no software is needed to arm a trace buffer transfer.

---
 rtl/tracer_udma_cfg_pkg.sv | 41 ++++
 rtl/tracer_poll_timer.sv | 35 +++
 rtl/tracer_udma_cfg_master.sv | 221 ++++++++++++++++++++++
 tb/tb_tracer_udma_cfg_master.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tracer_udma_cfg_pkg.sv
// Register map, CFG bit positions and sequencer states shared by the uDMA cfg master
// and the tracer adapter register interface.
package tracer_udma_cfg_pkg;

    localparam logic [4:0] REG_SADDR = 5'h00;
    localparam logic [4:0] REG_SIZE  = 5'h04;
    localparam logic [4:0] REG_CFG   = 5'h08;

    localparam int CFG_CONT_BIT   = 0;
    localparam int CFG_DS_LSB     = 1;
    localparam int CFG_FILTER_BIT = 3;
    localparam int CFG_EN_BIT     = 4;
    localparam int CFG_CLR_BIT    = 5;
    localparam int CFG_PEND_BIT   = 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_SADDR,
        ST_WR_SIZE,
        ST_WR_CFG,
        ST_WAIT,
        ST_RD_SADDR,
        ST_RD_SIZE,
        ST_RD_CFG,
        ST_WR_CLR,
        ST_FINISH
    } cfg_state_e;

    function automatic logic [31:0] cfg_word(input logic clr, input logic en, input logic filter,
                                             input logic [1:0] datasize, input logic cont);
        logic [31:0] w;
        w = '0;
        w[CFG_CLR_BIT]                = clr;
        w[CFG_EN_BIT]                 = en;
        w[CFG_FILTER_BIT]             = filter;
        w[CFG_DS_LSB+1:CFG_DS_LSB]    = datasize;
        w[CFG_CONT_BIT]               = cont;
        return w;
    endfunction

endpackage

// File: rtl/tracer_poll_timer.sv
// Loadable down-counter: after load it runs INTERVAL cycles (INTERVAL-1 .. 0) and flags
// terminal count once, in the last of them; a new load restarts it at any time.
module tracer_poll_timer #(
    parameter int unsigned INTERVAL = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic tc_o
);

    localparam int unsigned CW = $clog2(INTERVAL + 1);

    logic [CW-1:0] cnt_q;
    logic          armed_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else if (load_i) begin
            cnt_q   <= CW'(INTERVAL - 1);
            armed_q <= 1'b1;
        end else if (armed_q) begin
            if (cnt_q == '0) begin
                armed_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign tc_o = armed_q && (cnt_q == '0);

endmodule

// File: rtl/tracer_udma_cfg_master.sv
// Programs one uDMA RX channel over the cfg bus on start, then polls it until it drains
// or is aborted; every output is registered from the next FSM state.
module tracer_udma_cfg_master
    import tracer_udma_cfg_pkg::*;
#(
    parameter int unsigned L2_AWIDTH_NOAL = 12,
    parameter int unsigned TRANS_SIZE     = 16,
    parameter int unsigned POLL_INTERVAL  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [L2_AWIDTH_NOAL-1:0] buf_addr_i,
    input  logic [TRANS_SIZE-1:0]     buf_size_i,
    input  logic [1:0]                datasize_i,
    input  logic                      continuous_i,
    input  logic                      filter_i,
    input  logic                      abort_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      aborted_o,
    output logic                      err_o,
    output logic [TRANS_SIZE-1:0]     bytes_left_o,
    output logic [L2_AWIDTH_NOAL-1:0] curr_addr_o,
    output logic [31:0]               cfg_data_o,
    output logic [4:0]                cfg_addr_o,
    output logic                      cfg_valid_o,
    output logic                      cfg_rw_no,
    input  logic [31:0]               cfg_data_i,
    input  logic                      cfg_ready_i
);

    cfg_state_e state_q, state_d;

    logic [L2_AWIDTH_NOAL-1:0] addr_q, addr_d;
    logic [TRANS_SIZE-1:0]     size_q, size_d;
    logic [1:0]                ds_q, ds_d;
    logic                      cont_q, cont_d;
    logic                      filt_q, filt_d;
    logic                      abort_q, abort_d;

    logic                      busy_d, done_d, aborted_d, err_d;
    logic [TRANS_SIZE-1:0]     bytes_left_d;
    logic [L2_AWIDTH_NOAL-1:0] curr_addr_d;
    logic [31:0]               cfg_data_d;
    logic [4:0]                cfg_addr_d;
    logic                      cfg_valid_d, cfg_rw_d;

    logic hs, abort_pend, timer_load, timer_tc;
    logic cfg_data_unused;

    assign hs              = cfg_valid_o & cfg_ready_i;
    assign abort_pend      = abort_q | abort_i;
    assign cfg_data_unused = ^cfg_data_i;

    tracer_poll_timer #(
        .INTERVAL (POLL_INTERVAL)
    ) u_poll_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (timer_load),
        .tc_o   (timer_tc)
    );

    // Next state; an abort is only acted on at a transaction boundary or while waiting.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        ds_d       = ds_q;
        cont_d     = cont_q;
        filt_d     = filt_q;
        abort_d    = abort_q | abort_i;
        timer_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (start_i && (buf_size_i != '0)) begin
                    state_d = ST_WR_SADDR;
                    addr_d  = buf_addr_i;
                    size_d  = buf_size_i;
                    ds_d    = datasize_i;
                    cont_d  = continuous_i;
                    filt_d  = filter_i;
                end
            end
            ST_WR_SADDR: if (hs) state_d = abort_pend ? ST_WR_CLR : ST_WR_SIZE;
            ST_WR_SIZE:  if (hs) state_d = abort_pend ? ST_WR_CLR : ST_WR_CFG;
            ST_WR_CFG: begin
                if (hs) begin
                    state_d    = abort_pend ? ST_WR_CLR : ST_WAIT;
                    timer_load = !abort_pend;
                end
            end
            ST_WAIT: begin
                if (abort_pend)    state_d = ST_WR_CLR;
                else if (timer_tc) state_d = ST_RD_SADDR;
            end
            ST_RD_SADDR: if (hs) state_d = abort_pend ? ST_WR_CLR : ST_RD_SIZE;
            ST_RD_SIZE:  if (hs) state_d = abort_pend ? ST_WR_CLR : ST_RD_CFG;
            ST_RD_CFG: begin
                if (hs) begin
                    if (abort_pend) begin
                        state_d = ST_WR_CLR;
                    end else if (!cont_q && !cfg_data_i[CFG_EN_BIT] && !cfg_data_i[CFG_PEND_BIT]) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d    = ST_WAIT;
                        timer_load = 1'b1;
                    end
                end
            end
            ST_WR_CLR: if (hs) state_d = ST_FINISH;
            ST_FINISH: begin
                abort_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output registers are loaded from the state being entered, so they hold steady while stalled.
    always_comb begin
        cfg_valid_d = 1'b0;
        cfg_rw_d    = 1'b1;
        cfg_addr_d  = '0;
        cfg_data_d  = '0;

        case (state_d)
            ST_WR_SADDR: begin
                cfg_valid_d = 1'b1;
                cfg_rw_d    = 1'b0;
                cfg_addr_d  = REG_SADDR;
                cfg_data_d  = 32'(addr_d);
            end
            ST_WR_SIZE: begin
                cfg_valid_d = 1'b1;
                cfg_rw_d    = 1'b0;
                cfg_addr_d  = REG_SIZE;
                cfg_data_d  = 32'(size_d);
            end
            ST_WR_CFG: begin
                cfg_valid_d = 1'b1;
                cfg_rw_d    = 1'b0;
                cfg_addr_d  = REG_CFG;
                cfg_data_d  = cfg_word(1'b0, 1'b1, filt_d, ds_d, cont_d);
            end
            ST_RD_SADDR: begin
                cfg_valid_d = 1'b1;
                cfg_addr_d  = REG_SADDR;
            end
            ST_RD_SIZE: begin
                cfg_valid_d = 1'b1;
                cfg_addr_d  = REG_SIZE;
            end
            ST_RD_CFG: begin
                cfg_valid_d = 1'b1;
                cfg_addr_d  = REG_CFG;
            end
            ST_WR_CLR: begin
                cfg_valid_d = 1'b1;
                cfg_rw_d    = 1'b0;
                cfg_addr_d  = REG_CFG;
                cfg_data_d  = cfg_word(1'b1, 1'b0, filt_d, ds_d, cont_d);
            end
            default: ;
        endcase

        busy_d    = (state_d != ST_IDLE) && (state_d != ST_FINISH);
        done_d    = (state_d == ST_FINISH);
        aborted_d = (state_d == ST_FINISH) && (state_q == ST_WR_CLR);
        err_d     = (state_q == ST_IDLE) && start_i && (buf_size_i == '0);

        bytes_left_d = bytes_left_o;
        curr_addr_d  = curr_addr_o;
        if (hs && (state_q == ST_RD_SIZE))  bytes_left_d = cfg_data_i[TRANS_SIZE-1:0];
        if (hs && (state_q == ST_RD_SADDR)) curr_addr_d  = cfg_data_i[L2_AWIDTH_NOAL-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            size_q       <= '0;
            ds_q         <= '0;
            cont_q       <= 1'b0;
            filt_q       <= 1'b0;
            abort_q      <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            aborted_o    <= 1'b0;
            err_o        <= 1'b0;
            bytes_left_o <= '0;
            curr_addr_o  <= '0;
            cfg_valid_o  <= 1'b0;
            cfg_rw_no    <= 1'b1;
            cfg_addr_o   <= '0;
            cfg_data_o   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            ds_q         <= ds_d;
            cont_q       <= cont_d;
            filt_q       <= filt_d;
            abort_q      <= abort_d;
            busy_o       <= busy_d;
            done_o       <= done_d;
            aborted_o    <= aborted_d;
            err_o        <= err_d;
            bytes_left_o <= bytes_left_d;
            curr_addr_o  <= curr_addr_d;
            cfg_valid_o  <= cfg_valid_d;
            cfg_rw_no    <= cfg_rw_d;
            cfg_addr_o   <= cfg_addr_d;
            cfg_data_o   <= cfg_data_d;
        end
    end

endmodule

// File: tb/tb_tracer_udma_cfg_master.sv
// Directed bench for tracer_udma_cfg_master: expected cfg-bus transactions are queued as each
// step is driven and checked with cycle stamps by a bus monitor; a small channel model answers polls.
module tb_tracer_udma_cfg_master;

    localparam int P  = 4;
    localparam int AW = 12;
    localparam int TS = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, cont, filt, abort, ready;
    logic [AW-1:0] baddr;
    logic [TS-1:0] bsize;
    logic [1:0]    ds;
    logic          busy, done, aborted, err;
    logic [TS-1:0] bytes_left;
    logic [AW-1:0] curr_addr;
    logic [31:0]   cfg_data_o, cfg_data_i;
    logic [4:0]    cfg_addr;
    logic          cfg_valid, cfg_rw_n;

    always #5 clk = ~clk;

    tracer_udma_cfg_master #(
        .L2_AWIDTH_NOAL (AW),
        .TRANS_SIZE     (TS),
        .POLL_INTERVAL  (P)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .buf_addr_i   (baddr),
        .buf_size_i   (bsize),
        .datasize_i   (ds),
        .continuous_i (cont),
        .filter_i     (filt),
        .abort_i      (abort),
        .busy_o       (busy),
        .done_o       (done),
        .aborted_o    (aborted),
        .err_o        (err),
        .bytes_left_o (bytes_left),
        .curr_addr_o  (curr_addr),
        .cfg_data_o   (cfg_data_o),
        .cfg_addr_o   (cfg_addr),
        .cfg_valid_o  (cfg_valid),
        .cfg_rw_no    (cfg_rw_n),
        .cfg_data_i   (cfg_data_i),
        .cfg_ready_i  (ready)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        rw;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Channel model: address/size advance by 16 per poll round, en stays set for m_en_polls rounds.
    logic [31:0] m_base, m_size;
    int          m_en_polls;
    logic        m_clr;
    int          rnd;

    always @(posedge clk) begin
        if (m_clr) rnd <= 0;
        else if (cfg_valid && ready && cfg_rw_n && cfg_addr == 5'h08) rnd <= rnd + 1;
    end

    always_comb begin
        cfg_data_i = '0;
        case (cfg_addr)
            5'h00:   cfg_data_i = m_base + 32'(16 * (rnd + 1));
            5'h04:   cfg_data_i = m_size - 32'(16 * (rnd + 1));
            5'h08:   cfg_data_i = (rnd < m_en_polls) ? 32'h10 : 32'h0;
            default: cfg_data_i = '0;
        endcase
    end

    always @(negedge clk) begin
        if (cfg_valid === 1'b1 && ready === 1'b1) begin
            txn_t e;
            chk("txn_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("txn_rw", 32'(cfg_rw_n), 32'(e.rw));
                chk("txn_addr", 32'(cfg_addr), 32'(e.addr));
                if (!e.rw) chk("txn_wdata", cfg_data_o, e.data);
                chk("txn_cycle", 32'(cyc), e.cyc);
            end
        end
    end

    function automatic logic [31:0] exp_cfg(input logic clr, input logic en, input logic f,
                                            input logic [1:0] d, input logic c);
        return (32'(clr) << 5) | (32'(en) << 4) | (32'(f) << 3) | (32'(d) << 1) | 32'(c);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic rw, input logic [4:0] a, input logic [31:0] d, input int c);
        txn_t t;
        t.rw = rw; t.addr = a; t.data = d; t.cyc = 32'(c);
        exp_q.push_back(t);
    endtask

    task automatic push_writes(input int c0, input int stall, input logic [31:0] a, input logic [31:0] s,
                               input logic [1:0] d, input logic c, input logic f);
        push(1'b0, 5'h00, a, c0 + 1);
        push(1'b0, 5'h04, s, c0 + 2 + stall);
        push(1'b0, 5'h08, exp_cfg(1'b0, 1'b1, f, d, c), c0 + 3 + stall);
    endtask

    task automatic push_rounds(input int first, input int n);
        for (int r = 0; r < n; r++) begin
            push(1'b1, 5'h00, 32'h0, first + r * (3 + P));
            push(1'b1, 5'h04, 32'h0, first + r * (3 + P) + 1);
            push(1'b1, 5'h08, 32'h0, first + r * (3 + P) + 2);
        end
    endtask

    task automatic setup_model(input logic [31:0] b, input logic [31:0] s, input int en);
        m_base = b; m_size = s; m_en_polls = en; m_clr = 1'b1;
        step();
        m_clr = 1'b0;
    endtask

    task automatic start_xfer(input logic [AW-1:0] a, input logic [TS-1:0] s, input logic [1:0] d,
                              input logic c, input logic f);
        baddr = a; bsize = s; ds = d; cont = c; filt = f; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int t);
        t = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                t = cyc;
                break;
            end
        end
    endtask

    initial begin
        int c0, t, first;
        rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1;
        baddr = '0; bsize = '0; ds = '0; cont = 1'b0; filt = 1'b0;
        m_base = '0; m_size = '0; m_en_polls = 0; m_clr = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_valid", 32'(cfg_valid), 32'd0);
        chk("rst_rw", 32'(cfg_rw_n), 32'd1);
        chk("rst_addr", 32'(cfg_addr), 32'd0);
        chk("rst_data", cfg_data_o, 32'd0);
        chk("rst_flags", {28'd0, busy, done, aborted, err}, 32'd0);
        chk("rst_bytes", 32'(bytes_left), 32'd0);
        chk("rst_curr", 32'(curr_addr), 32'd0);
        rst = 1'b0; m_clr = 1'b0;
        step();

        // Normal transfer: three polls with en set, drains on the fourth.
        setup_model(32'h123, 32'h40, 3);
        c0 = cyc; first = c0 + 4 + P;
        push_writes(c0, 0, 32'h123, 32'h40, 2'd2, 1'b0, 1'b1);
        push_rounds(first, 4);
        start_xfer(12'h123, 16'h40, 2'd2, 1'b0, 1'b1);
        @(negedge clk);
        chk("t1_busy_c1", 32'(busy), 32'd1);
        wait_done(t);
        chk("t1_done_cycle", 32'(t), 32'(first + 3 * (3 + P) + 3));
        chk("t1_busy_at_done", 32'(busy), 32'd0);
        chk("t1_aborted", 32'(aborted), 32'd0);
        chk("t1_bytes_left", 32'(bytes_left), 32'h0);
        chk("t1_curr_addr", 32'(curr_addr), 32'h163);
        step();
        @(negedge clk);
        chk("t1_done_pulse", 32'(done), 32'd0);

        // Backpressure: ready low for 5 cycles during the SIZE write.
        setup_model(32'h300, 32'h10, 0);
        c0 = cyc; first = c0 + 4 + P + 5;
        push_writes(c0, 5, 32'h300, 32'h10, 2'd0, 1'b0, 1'b0);
        push_rounds(first, 1);
        start_xfer(12'h300, 16'h10, 2'd0, 1'b0, 1'b0);
        step();
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t2_hold_valid", 32'(cfg_valid), 32'd1);
            chk("t2_hold_addr", 32'(cfg_addr), 32'h04);
            chk("t2_hold_data", cfg_data_o, 32'h10);
            step();
        end
        ready = 1'b1;
        wait_done(t);
        chk("t2_done_cycle", 32'(t), 32'(first + 3));
        chk("t2_curr_addr", 32'(curr_addr), 32'h310);
        chk("t2_bytes_left", 32'(bytes_left), 32'h0);
        step();

        // Continuous mode aborted during WAIT.
        setup_model(32'h200, 32'h80, 100);
        c0 = cyc;
        push_writes(c0, 0, 32'h200, 32'h80, 2'd0, 1'b1, 1'b0);
        push(1'b0, 5'h08, 32'h21, c0 + 6);
        start_xfer(12'h200, 16'h80, 2'd0, 1'b1, 1'b0);
        repeat (4) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_done(t);
        chk("t3_done_cycle", 32'(t), 32'(c0 + 7));
        chk("t3_aborted", 32'(aborted), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        step();
        @(negedge clk);
        chk("t3_aborted_pulse", 32'(aborted), 32'd0);

        // Zero size start is rejected.
        start_xfer(12'h010, 16'h0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_valid", 32'(cfg_valid), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        step();
        @(negedge clk);
        chk("t4_err_pulse", 32'(err), 32'd0);
        chk("t4_busy_after", 32'(busy), 32'd0);
        step();

        // Reset while the SIZE write is stalled, then a clean restart.
        setup_model(32'h050, 32'h20, 0);
        c0 = cyc;
        push(1'b0, 5'h00, 32'h050, c0 + 1);
        start_xfer(12'h050, 16'h20, 2'd1, 1'b0, 1'b0);
        step();
        ready = 1'b0;
        @(negedge clk);
        chk("t5_size_pending", 32'(cfg_addr), 32'h04);
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("t5_rst_valid", 32'(cfg_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_rw", 32'(cfg_rw_n), 32'd1);
        rst = 1'b0;
        ready = 1'b1;
        step();
        setup_model(32'h050, 32'h20, 0);
        c0 = cyc; first = c0 + 4 + P;
        push_writes(c0, 0, 32'h050, 32'h20, 2'd1, 1'b0, 1'b0);
        push_rounds(first, 1);
        start_xfer(12'h050, 16'h20, 2'd1, 1'b0, 1'b0);
        wait_done(t);
        chk("t5_done_cycle", 32'(t), 32'(first + 3));
        chk("t5_bytes_left", 32'(bytes_left), 32'h10);
        chk("t5_curr_addr", 32'(curr_addr), 32'h060);
        step();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
